pin_debouncer: RTL and testbench
================================

// Module: pin_debouncer
// PURPOSE
//  Debounce stage directly downstream of the two-flop pin synchronizer. Consumes the
//  already-synchronized pin level, accepts a new level only after it has been stable
//  for STABLE_CNT+1 consecutive clocks, and emits the clean level, one-cycle rise/fall
//  pulses and a wrapping count of accepted rising edges, for buttons and switches.
// PARAMETERS
//  CNT_W       16     width of stability counter; require STABLE_CNT <= 2**CNT_W-1
//  STABLE_CNT  50000  extra consecutive stable samples required (>=1; 1 ms @ 50 MHz)
//  RESET_LVL   1'b0   debounced level (and FSM side) taken at reset
//  EVT_W       8      width of rising-event counter
// PORTS
//  clk       in   1      system clock; all state on rising edge
//  rst       in   1      reset, asynchronous, active-high
//  sync_in   in   1      synchronized pin level (output of synchronizer stage)
//  level     out  1      debounced level (registered)
//  rise      out  1      one-cycle pulse, same edge that level goes 0->1
//  fall      out  1      one-cycle pulse, same edge that level goes 1->0
//  busy      out  1      1 while in a WAIT state (candidate change being timed)
//  evt_cnt   out  EVT_W  count of accepted rising edges, wraps
// BEHAVIOUR
//  - Reset (async assert, sync release at clk): state=IDLE_LO if RESET_LVL=0 else IDLE_HI;
//    level=RESET_LVL, rise=fall=busy=0, cnt=0, evt_cnt=0. Reset mid-WAIT aborts the
//    candidate; no pulse is emitted.
//  - States: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO (4-state Moore for level/busy).
//  - IDLE_LO: sync_in=1 -> WAIT_HI, cnt<=0. Else stay.
//  - WAIT_HI: sync_in=0 -> IDLE_LO (bounce, candidate dropped, no pulse, cnt<=0).
//    sync_in=1 and cnt==STABLE_CNT-1 -> IDLE_HI, level<=1, rise<=1, evt_cnt<=evt_cnt+1.
//    sync_in=1 otherwise -> cnt<=cnt+1.
//  - IDLE_HI / WAIT_LO: mirror of the above with polarity swapped; fall instead of rise;
//    evt_cnt unchanged.
//  - Latency: level changes on the edge at which sync_in has been sampled at the new value
//    on STABLE_CNT+1 consecutive edges. Any opposite sample restarts the count from zero.
//  - rise/fall are registered, high for exactly one cycle, never both in one cycle.
//    Minimum spacing between a rise and the next fall is STABLE_CNT+1 cycles.
//  - busy=1 exactly in WAIT_HI/WAIT_LO.
//  - evt_cnt wraps 2**EVT_W-1 -> 0 with no flag.
//  - cnt never exceeds STABLE_CNT-1; no saturation logic needed.
//  - sync_in held at current level: FSM stays idle, no outputs toggle.
// STRUCTURE
//  - Shared package/header (io_pkg): state encodings (IDLE_LO=2'b00, WAIT_HI=2'b01,
//    IDLE_HI=2'b10, WAIT_LO=2'b11); default debounce constants.
//  - One sub-module: debounce_timer (CNT_W counter with clr/inc inputs and
//    done = cnt==STABLE_CNT-1 output).
//  - FSM, output registers and evt_cnt live in pin_debouncer.
//  - No internal synchronizer: sync_in must already be synchronous to clk.
// TESTING (STABLE_CNT=4, EVT_W=2, RESET_LVL=0)
//  1. Reset, then sync_in=0 for 10 cycles -> level=0, rise=fall=busy=0, evt_cnt=0.
//  2. sync_in 0->1 and held -> busy=1 next cycle; level=1, rise=1 for one cycle on the
//     5th sampling edge; evt_cnt=1.
//  3. Bounce: sync_in=1 for 3 cycles, 0 for 1, then 1 held -> no pulse until 5 consecutive
//     highs after the drop; exactly one rise.
//  4. From level=1: sync_in=0 held -> fall=1 for one cycle after 5 edges; evt_cnt unchanged.
//  5. Four accepted presses -> evt_cnt goes 1,2,3,0 (wrap).
//  6. Assert rst asynchronously mid-WAIT_HI (cnt=2) -> level=0 and busy=0 immediately;
//     no rise afterwards.

Source files
------------

// File: rtl/pin_debouncer_pkg.sv
// Shared definitions for the pin debouncer: FSM state encodings and
// default debounce constants.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b10,
        WAIT_LO = 2'b11
    } dbnc_state_e;

    localparam int   DEF_CNT_W      = 16;
    localparam int   DEF_STABLE_CNT = 50000;   // 1 ms at 50 MHz
    localparam int   DEF_EVT_W      = 8;
    localparam logic DEF_RESET_LVL  = 1'b0;

    // Idle state that corresponds to a given debounced level.
    function automatic dbnc_state_e idle_state(input logic lvl);
        return lvl ? IDLE_HI : IDLE_LO;
    endfunction

endpackage

// File: rtl/pin_debouncer_if.sv
// Pin-side bundle of the debouncer: synchronized input plus clean outputs.
interface pin_debouncer_if #(
    parameter int EVT_W = 8
) ();

    logic             sync_in;
    logic             level;
    logic             rise;
    logic             fall;
    logic             busy;
    logic [EVT_W-1:0] evt_cnt;

    // Producer of sync_in / consumer of the debounced outputs.
    modport master (
        output sync_in,
        input  level, rise, fall, busy, evt_cnt
    );

    // The debouncer itself.
    modport slave (
        input  sync_in,
        output level, rise, fall, busy, evt_cnt
    );

endinterface

// File: rtl/pin_debouncer_timer.sv
// Stability counter: clears on clr, counts on inc, flags the last
// count before a candidate level is accepted.
module debounce_timer #(
    parameter int CNT_W      = 16,
    parameter int STABLE_CNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    logic [CNT_W-1:0] cnt;

    // Clear has priority so a bounce always restarts timing from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end

    assign done = (cnt == CNT_W'(STABLE_CNT - 1));

endmodule

// File: rtl/pin_debouncer.sv
// Debounce stage for an already-synchronized pin: 4-state FSM accepting a
// new level after STABLE_CNT+1 consecutive equal samples, with registered
// rise/fall pulses and a wrapping count of accepted rising edges.
module pin_debouncer
    import io_pkg::*;
#(
    parameter int   CNT_W      = DEF_CNT_W,
    parameter int   STABLE_CNT = DEF_STABLE_CNT,
    parameter logic RESET_LVL  = DEF_RESET_LVL,
    parameter int   EVT_W      = DEF_EVT_W
) (
    input  logic           clk,
    input  logic           rst,
    pin_debouncer_if.slave pif
);

    dbnc_state_e      state_q, state_d;
    logic             tmr_clr, tmr_inc, tmr_done;
    logic             do_rise, do_fall;
    logic             level_q, rise_q, fall_q;
    logic [EVT_W-1:0] evt_q;

    debounce_timer #(
        .CNT_W      (CNT_W),
        .STABLE_CNT (STABLE_CNT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .inc  (tmr_inc),
        .done (tmr_done)
    );

    // State register; reset lands in the idle state matching RESET_LVL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= idle_state(RESET_LVL);
        else     state_q <= state_d;
    end

    // Next-state logic. The timer is held clear everywhere except while a
    // candidate is still being timed, so entering a WAIT starts from zero.
    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b1;
        tmr_inc = 1'b0;
        do_rise = 1'b0;
        do_fall = 1'b0;
        case (state_q)
            IDLE_LO: if (pif.sync_in) state_d = WAIT_HI;
            WAIT_HI: begin
                if (!pif.sync_in) begin
                    state_d = IDLE_LO;
                end else if (tmr_done) begin
                    state_d = IDLE_HI;
                    do_rise = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_inc = 1'b1;
                end
            end
            IDLE_HI: if (!pif.sync_in) state_d = WAIT_LO;
            WAIT_LO: begin
                if (pif.sync_in) begin
                    state_d = IDLE_HI;
                end else if (tmr_done) begin
                    state_d = IDLE_LO;
                    do_fall = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_inc = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Registered level and one-cycle edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= RESET_LVL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= do_rise;
            fall_q <= do_fall;
            if (do_rise)      level_q <= 1'b1;
            else if (do_fall) level_q <= 1'b0;
        end
    end

    // Accepted rising edges; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          evt_q <= '0;
        else if (do_rise) evt_q <= evt_q + 1'b1;
    end

    assign pif.level   = level_q;
    assign pif.rise    = rise_q;
    assign pif.fall    = fall_q;
    assign pif.busy    = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign pif.evt_cnt = evt_q;

endmodule

// File: tb/tb_pin_debouncer.sv
// Scoreboard bench for pin_debouncer: the driver feeds sync_in and pushes
// the run-length model's expected outputs; the monitor pops and compares.
module tb_pin_debouncer;

    localparam int SC = 4;
    localparam int EW = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pin_debouncer_if #(.EVT_W(EW)) pif ();

    pin_debouncer #(
        .CNT_W      (16),
        .STABLE_CNT (SC),
        .RESET_LVL  (1'b0),
        .EVT_W      (EW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif.slave)
    );

    typedef struct {
        logic          level;
        logic          rise;
        logic          fall;
        logic          busy;
        logic [EW-1:0] evt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: accepted level, length of the current run of samples
    // that differ from it, and number of accepted rises.
    bit m_lvl = 1'b0;
    int m_run = 0;
    int m_evt = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    endtask

    task automatic model_reset();
        m_lvl = 1'b0;
        m_run = 0;
        m_evt = 0;
        sb.delete();
    endtask

    // A level is accepted once it has been seen on SC+1 consecutive samples.
    task automatic model_step(input bit v);
        exp_t e;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (v != m_lvl) begin
            m_run++;
            if (m_run == SC + 1) begin
                m_lvl = v;
                m_run = 0;
                if (v) begin
                    e.rise = 1'b1;
                    m_evt  = (m_evt + 1) % (1 << EW);
                end else begin
                    e.fall = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        e.level = m_lvl;
        e.busy  = (m_run > 0);
        e.evt   = EW'(m_evt);
        sb.push_back(e);
    endtask

    task automatic drive(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pif.sync_in = v;
            model_step(v);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_level"}, 8'(pif.level),   8'd0);
        chk({tag, "_rise"},  8'(pif.rise),    8'd0);
        chk({tag, "_fall"},  8'(pif.fall),    8'd0);
        chk({tag, "_busy"},  8'(pif.busy),    8'd0);
        chk({tag, "_evt"},   8'(pif.evt_cnt), 8'd0);
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("level", 8'(pif.level),   8'(e.level));
            chk("rise",  8'(pif.rise),    8'(e.rise));
            chk("fall",  8'(pif.fall),    8'(e.fall));
            chk("busy",  8'(pif.busy),    8'(e.busy));
            chk("evt",   8'(pif.evt_cnt), 8'(e.evt));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        pif.sync_in = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk_reset_state("rst");
        rst = 1'b0;

        // Quiet low input, then a clean press and release.
        drive(1'b0, 10);
        drive(1'b1, 8);
        drive(1'b0, 8);

        // Bounce during a rising candidate.
        drive(1'b1, 3);
        drive(1'b0, 1);
        drive(1'b1, 8);
        drive(1'b0, 8);

        // Four presses to wrap the event counter.
        repeat (4) begin
            drive(1'b1, 6);
            drive(1'b0, 6);
        end

        // Async reset in the middle of WAIT_HI (timer at 2).
        drive(1'b1, 3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_state("midwait");
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        drive(1'b0, 6);

        // Random runs, mixing bounces shorter than the window with long holds.
        repeat (300) drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));

        @(posedge clk);
        #3;
        chk("drained", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
